seq_mac: RTL and testbench

- Parametrised sequential multiply-accumulate unit; next-generation successor to the combinational mult/fma exploration components.
- Radix-2 shift-add multiplier taking WIDTH cycles per operation, with optional accumulation into a guarded accumulator and a start/busy/done handshake.
- Sits under the size-exploration top level as an alternative COMPONENT. The top level drives start from a shift-register strobe and reads out via its byte muxes.
- Trades area against latency for comparison with the combinational variants.

---
 rtl/seq_mac.sv | 124 ++++++++++++
 tb/tb_seq_mac.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_mac.sv
// seq_mac: radix-2 shift-add multiplier with optional accumulation.
// One multiplier bit is consumed per RUN cycle; the finished product is folded
// into the guarded accumulator on the edge that enters DONE, so out only moves
// in DONE, on acc_clear or on reset.
module seq_mac #(
    parameter int WIDTH  = 8,
    parameter int GUARD  = 4,
    parameter int SIGNED = 0
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      start,
    input  logic                      mode,
    input  logic                      acc_clear,
    input  logic [WIDTH-1:0]          ina,
    input  logic [WIDTH-1:0]          inb,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [2*WIDTH+GUARD-1:0]  out
);
    localparam int PW = 2 * WIDTH;
    localparam int AW = PW + GUARD;
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    logic [PW-1:0]    r_mcand;   // multiplicand, pre-shifted by the step count
    logic [WIDTH-1:0] r_mplier;  // multiplier, bit 0 is the current step's bit
    logic [PW-1:0]    r_pp;
    logic [CW-1:0]    r_cnt;
    logic             r_mode;
    logic [AW-1:0]    r_out;
    logic             r_busy;
    logic             r_done;
    logic             r_ovf;

    logic [PW-1:0]    w_a_ext;
    logic             w_last;
    logic             w_sub;
    logic [PW-1:0]    w_pp_next;
    logic [AW-1:0]    w_prod;
    logic [AW:0]      w_sum;
    logic             w_ovf;

    // Operand extension, one shift-add step, and the final accumulate/overflow.
    // The signed MSB step subtracts because the top multiplier bit weighs -2^(W-1).
    always_comb begin
        w_a_ext   = (SIGNED != 0) ? PW'($signed(ina)) : PW'(ina);
        w_last    = (r_cnt == CW'(WIDTH - 1));
        w_sub     = (SIGNED != 0) && w_last;
        w_pp_next = r_pp;
        if (r_mplier[0])
            w_pp_next = w_sub ? (r_pp - r_mcand) : (r_pp + r_mcand);
        w_prod    = (SIGNED != 0) ? AW'($signed(w_pp_next)) : AW'(w_pp_next);
        w_sum     = {1'b0, r_out} + {1'b0, w_prod};
        if (SIGNED != 0)
            w_ovf = (r_out[AW-1] == w_prod[AW-1]) && (w_sum[AW-1] != r_out[AW-1]);
        else
            w_ovf = w_sum[AW];
    end

    // Control FSM plus datapath registers; enable freezes everything, reset wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_pp     <= '0;
            r_cnt    <= '0;
            r_mode   <= 1'b0;
            r_out    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_ovf    <= 1'b0;
        end else if (enable) begin
            case (r_state)
                S_RUN: begin
                    r_pp     <= w_pp_next;
                    r_mcand  <= r_mcand << 1;
                    r_mplier <= r_mplier >> 1;
                    r_cnt    <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_out   <= r_mode ? w_sum[AW-1:0] : w_prod;
                        if (r_mode && w_ovf)
                            r_ovf <= 1'b1;
                    end
                end
                default: begin
                    // IDLE and DONE both accept a clear and a new start;
                    // the clear lands first so a MAC started now begins from 0.
                    r_done <= 1'b0;
                    if (acc_clear) begin
                        r_out <= '0;
                        r_ovf <= 1'b0;
                    end
                    if (start) begin
                        r_state  <= S_RUN;
                        r_busy   <= 1'b1;
                        r_mcand  <= w_a_ext;
                        r_mplier <= inb;
                        r_mode   <= mode;
                        r_pp     <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_state  <= S_IDLE;
                        r_busy   <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign overflow = r_ovf;
    assign out      = r_out;

endmodule

// File: tb/tb_seq_mac.sv
// Bench for seq_mac: an unsigned and a signed instance share one stimulus
// stream. A cycle-level integer model predicts busy/done/out/overflow for both
// and is compared every cycle; directed checks pin literal results and timing.
module tb_seq_mac;
    localparam int  WIDTH = 8;
    localparam int  GUARD = 4;
    localparam int  AW    = 2 * WIDTH + GUARD;
    localparam longint MOD = longint'(1) << AW;

    logic clk = 1'b0;
    logic reset = 1'b1, enable = 1'b1, start = 1'b0, mode = 1'b0, acc_clear = 1'b0;
    logic [WIDTH-1:0] ina = '0, inb = '0;
    logic          busy0, done0, ovf0, busy1, done1, ovf1;
    logic [AW-1:0] out0, out1;

    int n_err = 0;
    int n_chk = 0;

    always #5 clk = ~clk;

    seq_mac #(.WIDTH(WIDTH), .GUARD(GUARD), .SIGNED(0)) u_uns (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
        .acc_clear(acc_clear), .ina(ina), .inb(inb),
        .busy(busy0), .done(done0), .overflow(ovf0), .out(out0));

    seq_mac #(.WIDTH(WIDTH), .GUARD(GUARD), .SIGNED(1)) u_sgn (
        .clk(clk), .reset(reset), .enable(enable), .start(start), .mode(mode),
        .acc_clear(acc_clear), .ina(ina), .inb(inb),
        .busy(busy1), .done(done1), .overflow(ovf1), .out(out1));

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- model: index 0 unsigned, 1 signed ----------------
    logic   m_busy [2];
    logic   m_done [2];
    logic   m_ovf  [2];
    longint m_out  [2];
    longint m_prod [2];
    logic   m_mode [2];
    int     m_left [2];

    function automatic longint wrap(input longint v);
        longint r;
        r = v % MOD;
        if (r < 0) r += MOD;
        return r;
    endfunction

    function automatic longint as_signed(input longint v);
        return (v >= MOD / 2) ? v - MOD : v;
    endfunction

    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                m_busy[k] = 1'b0; m_done[k] = 1'b0; m_ovf[k] = 1'b0;
                m_out[k]  = 0;    m_left[k] = 0;    m_prod[k] = 0; m_mode[k] = 1'b0;
            end else if (enable) begin
                if (m_busy[k]) begin
                    m_left[k]--;
                    if (m_left[k] == 0) begin
                        m_busy[k] = 1'b0;
                        m_done[k] = 1'b1;
                        if (!m_mode[k]) begin
                            m_out[k] = wrap(m_prod[k]);
                        end else if (k == 0) begin
                            if (m_out[k] + m_prod[k] >= MOD) m_ovf[k] = 1'b1;
                            m_out[k] = wrap(m_out[k] + m_prod[k]);
                        end else begin
                            longint s;
                            s = as_signed(m_out[k]) + m_prod[k];
                            if (s < -(MOD / 2) || s >= MOD / 2) m_ovf[k] = 1'b1;
                            m_out[k] = wrap(s);
                        end
                    end
                end else begin
                    m_done[k] = 1'b0;
                    if (acc_clear) begin
                        m_out[k] = 0;
                        m_ovf[k] = 1'b0;
                    end
                    if (start) begin
                        if (k == 0) m_prod[k] = longint'(ina) * longint'(inb);
                        else        m_prod[k] = longint'($signed(ina)) * longint'($signed(inb));
                        m_mode[k] = mode;
                        m_busy[k] = 1'b1;
                        m_left[k] = WIDTH;
                    end
                end
            end
        end
    end

    // Per-cycle comparison of both instances against the model.
    always @(posedge clk) begin
        #1;
        check("u_uns.busy", longint'(busy0), longint'(m_busy[0]));
        check("u_uns.done", longint'(done0), longint'(m_done[0]));
        check("u_uns.ovf",  longint'(ovf0),  longint'(m_ovf[0]));
        check("u_uns.out",  longint'(out0),  m_out[0]);
        check("u_sgn.busy", longint'(busy1), longint'(m_busy[1]));
        check("u_sgn.done", longint'(done1), longint'(m_done[1]));
        check("u_sgn.ovf",  longint'(ovf1),  longint'(m_ovf[1]));
        check("u_sgn.out",  longint'(out1),  m_out[1]);
    end

    // hook: 0 none, 1 start+acc_clear pulse mid-RUN, 2 enable low 3 cycles mid-RUN.
    // lat counts cycles from the accepting edge to the cycle showing done (-1 = timeout).
    task automatic run_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic m, input int hook, output int lat);
        int k;
        @(negedge clk);
        ina = a; inb = b; mode = m; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = -1;
        k = 1;
        while (k <= 60) begin
            @(posedge clk); #1;
            if (done0) begin
                lat = k + 1;
                break;
            end
            if (k == 3 && hook == 1) begin
                @(negedge clk); start = 1'b1; acc_clear = 1'b1; ina = 8'd99;
                @(negedge clk); start = 1'b0; acc_clear = 1'b0; ina = a;
                k += 1;
            end else if (k == 3 && hook == 2) begin
                @(negedge clk); enable = 1'b0;
                repeat (3) @(negedge clk);
                enable = 1'b1;
                k += 3;
            end
            k++;
        end
    endtask

    task automatic pulse_clear();
        @(negedge clk); acc_clear = 1'b1;
        @(negedge clk); acc_clear = 1'b0;
    endtask

    initial begin
        int lat, cnt, last, ndone;
        longint exp_b2b [4];
        exp_b2b = '{40000, 80000, 120000, 160000};

        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset out", longint'(out0), 0);
        check("reset busy", longint'(busy0), 0);
        check("reset ovf", longint'(ovf1), 0);

        // 255*255 multiply
        run_op(8'd255, 8'd255, 1'b0, 0, lat);
        check("mul latency", lat, WIDTH + 1);
        check("mul 255*255", longint'(out0), 65025);
        check("mul -1*-1", longint'(out1), 1);
        check("mul ovf", longint'(ovf0), 0);

        // four back-to-back MACs with start held high
        pulse_clear();
        @(negedge clk); ina = 8'd200; inb = 8'd200; mode = 1'b1; start = 1'b1;
        cnt = 0; last = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk); #1;
            if (done0) begin
                check("b2b out", longint'(out0), exp_b2b[cnt]);
                if (cnt > 0) check("b2b spacing", c - last, WIDTH + 1);
                cnt++; last = c;
                if (cnt == 4) break;
            end
        end
        @(negedge clk); start = 1'b0;
        check("b2b count", cnt, 4);
        check("b2b signed sum", longint'(out1), 12544);
        check("b2b ovf", longint'(ovf0), 0);

        // 26 accumulations of 255*255 into a 20-bit accumulator
        pulse_clear();
        for (int i = 1; i <= 26; i++) begin
            run_op(8'd255, 8'd255, 1'b1, 0, lat);
            if (i == 16) begin
                check("mac16 out", longint'(out0), 1040400);
                check("mac16 ovf", longint'(ovf0), 0);
            end
            if (i == 17) begin
                check("mac17 out", longint'(out0), 56849);
                check("mac17 ovf", longint'(ovf0), 1);
            end
        end
        check("mac26 out", longint'(out0), 642074);
        check("mac26 ovf sticky", longint'(ovf0), 1);
        check("mac26 signed out", longint'(out1), 26);
        pulse_clear();
        check("clear out", longint'(out0), 0);
        check("clear ovf", longint'(ovf0), 0);

        // signed corner operands
        run_op(8'h80, 8'h80, 1'b0, 0, lat);
        check("-128*-128", longint'(out1), 16384);
        check("128*128", longint'(out0), 16384);
        run_op(8'hFF, 8'h7F, 1'b0, 0, lat);
        check("-1*127", longint'(out1), 20'hFFF81);
        check("255*127", longint'(out0), 32385);

        // start and acc_clear mid-RUN are ignored
        run_op(8'd10, 8'd20, 1'b0, 0, lat);
        run_op(8'd7, 8'd9, 1'b1, 1, lat);
        check("ignore latency", lat, WIDTH + 1);
        check("ignore out", longint'(out0), 263);

        // enable low for 3 cycles mid-RUN
        run_op(8'd12, 8'd13, 1'b0, 2, lat);
        check("stall latency", lat, WIDTH + 4);
        check("stall out", longint'(out0), 156);

        // reset at RUN cycle 4 aborts the operation
        @(negedge clk); ina = 8'd9; inb = 8'd9; mode = 1'b0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        check("abort busy", longint'(busy0), 0);
        check("abort out", longint'(out0), 0);
        ndone = 0;
        repeat (12) begin
            @(posedge clk); #1;
            if (done0 || done1) ndone++;
        end
        check("abort no done", ndone, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
